// File: rtl/conv_encoder_frame.sv
// conv_encoder_frame: rate-1/2, K=3 convolutional encoder (g0=111, g1=101).
// Loads one frame of FRAME_LEN bits on st and emits one 2-bit symbol per
// sym_valid/sym_ready handshake, LSB of the frame first.
// Optional build macro: ZERO_TAIL_EN appends two zero flush bits so the
// trellis ends in state 00. Without it the frame ends after the last data bit.
module conv_encoder_frame #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 st,
  input  logic [FRAME_LEN-1:0] data_frame,
  input  logic                 sym_ready,
  output logic [1:0]           sym_out,
  output logic                 sym_valid,
  output logic                 busy,
  output logic                 done
);

`ifdef ZERO_TAIL_EN
  typedef enum logic [1:0] {IDLE, ENC, TAIL, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST_TAIL = CNT_W'(FRAME_LEN + 1);
`else
  typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;
`endif

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

  state_t               state;
  logic [FRAME_LEN-1:0] frame;
  logic                 s1;
  logic                 s2;
  logic [CNT_W-1:0]     cnt;
  logic                 u;
  logic                 accept;

  // The frame register shifts right on every accepted data symbol, so the
  // current information bit is always frame[0]; tail bits are zero.
  assign u       = (state == ENC) ? frame[0] : 1'b0;
  assign accept  = sym_valid && sym_ready;
  assign sym_out = sym_valid ? {u ^ s1 ^ s2, u ^ s2} : 2'b00;

  // Frame control FSM with registered sym_valid/busy/done and encoder state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      frame     <= '0;
      s1        <= 1'b0;
      s2        <= 1'b0;
      cnt       <= '0;
      sym_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (st) begin
            frame     <= data_frame;
            s1        <= 1'b0;
            s2        <= 1'b0;
            cnt       <= '0;
            sym_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= ENC;
          end
        end
        ENC: begin
          if (accept) begin
            s2    <= s1;
            s1    <= u;
            frame <= frame >> 1;
            cnt   <= cnt + CNT_W'(1);
            if (cnt == LAST_BIT) begin
`ifdef ZERO_TAIL_EN
              state     <= TAIL;
`else
              state     <= DONE;
              sym_valid <= 1'b0;
              done      <= 1'b1;
`endif
            end
          end
        end
`ifdef ZERO_TAIL_EN
        TAIL: begin
          if (accept) begin
            s2  <= s1;
            s1  <= 1'b0;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_TAIL) begin
              state     <= DONE;
              sym_valid <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
`endif
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          sym_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
